// File: rtl/seg_disp_ctrl.sv
// Update controller and two-requester arbiter for the seven-segment display driver.
// Define SEG_DISP_RR_ARB_EN for round-robin arbitration; default is fixed priority (dbg over cpu).
module seg_disp_ctrl #(
    parameter int unsigned BLANK_CYC = 8,
    parameter int unsigned MIN_GAP   = 16,
    parameter logic [31:0] INIT_VAL  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [31:0] cpu_data,
    input  logic [3:0]  cpu_be,
    output logic        cpu_gnt,
    input  logic        dbg_req,
    input  logic [31:0] dbg_data,
    input  logic [3:0]  dbg_be,
    output logic        dbg_gnt,
    output logic        busy,
    output logic [7:0]  z1,
    output logic [7:0]  r1,
    output logic [7:0]  z2,
    output logic [7:0]  r2,
    output logic        upd_done
);

    typedef enum logic [1:0] {StIdle, StBlank, StCommit} state_e;

    state_e      state_q, state_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  blk_cnt_q, blk_cnt_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic [3:0]  pend_be_q, pend_be_d;
    logic [31:0] disp_q, disp_d;
    logic        cpu_gnt_q, cpu_gnt_d;
    logic        dbg_gnt_q, dbg_gnt_d;
    logic        busy_q, busy_d;
    logic        upd_done_q, upd_done_d;
    logic        pick_dbg;
    logic        accept;

`ifdef SEG_DISP_RR_ARB_EN
    logic last_dbg_q, last_dbg_d;

    // On a tie the requester not granted last wins.
    assign pick_dbg = dbg_req & (~cpu_req | ~last_dbg_q);

    always_comb begin
        last_dbg_d = last_dbg_q;
        if (accept) begin
            last_dbg_d = pick_dbg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dbg_q <= 1'b1;
        end else begin
            last_dbg_q <= last_dbg_d;
        end
    end
`else
    assign pick_dbg = dbg_req;
`endif

    assign accept = (state_q == StIdle) && (gap_cnt_q == 8'd0) && (cpu_req || dbg_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StBlank;
            StBlank:  if (blk_cnt_q == 8'd0) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        gap_cnt_d   = gap_cnt_q;
        blk_cnt_d   = blk_cnt_q;
        pend_data_d = pend_data_q;
        pend_be_d   = pend_be_q;
        disp_d      = disp_q;
        busy_d      = busy_q;
        cpu_gnt_d   = 1'b0;
        dbg_gnt_d   = 1'b0;
        upd_done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gap_cnt_q != 8'd0) begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end else if (accept) begin
                    pend_data_d = pick_dbg ? dbg_data : cpu_data;
                    pend_be_d   = pick_dbg ? dbg_be : cpu_be;
                    dbg_gnt_d   = pick_dbg;
                    cpu_gnt_d   = ~pick_dbg;
                    busy_d      = 1'b1;
                    blk_cnt_d   = 8'(BLANK_CYC - 1);
                end
            end
            StBlank: begin
                if (blk_cnt_q == 8'd0) begin
                    busy_d     = 1'b0;
                    upd_done_d = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        if (pend_be_q[i]) begin
                            disp_d[i*8 +: 8] = pend_data_q[i*8 +: 8];
                        end
                    end
                end else begin
                    blk_cnt_d = blk_cnt_q - 8'd1;
                end
            end
            StCommit: begin
                gap_cnt_d = 8'(MIN_GAP);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_q   <= 8'd0;
            blk_cnt_q   <= 8'd0;
            pend_data_q <= 32'd0;
            pend_be_q   <= 4'd0;
            disp_q      <= INIT_VAL;
            busy_q      <= 1'b0;
            cpu_gnt_q   <= 1'b0;
            dbg_gnt_q   <= 1'b0;
            upd_done_q  <= 1'b0;
        end else begin
            gap_cnt_q   <= gap_cnt_d;
            blk_cnt_q   <= blk_cnt_d;
            pend_data_q <= pend_data_d;
            pend_be_q   <= pend_be_d;
            disp_q      <= disp_d;
            busy_q      <= busy_d;
            cpu_gnt_q   <= cpu_gnt_d;
            dbg_gnt_q   <= dbg_gnt_d;
            upd_done_q  <= upd_done_d;
        end
    end

    assign z1       = disp_q[31:24];
    assign r1       = disp_q[23:16];
    assign z2       = disp_q[15:8];
    assign r2       = disp_q[7:0];
    assign busy     = busy_q;
    assign cpu_gnt  = cpu_gnt_q;
    assign dbg_gnt  = dbg_gnt_q;
    assign upd_done = upd_done_q;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Directed self-checking bench for seg_disp_ctrl (BLANK_CYC=8, MIN_GAP=16, INIT_VAL=32'h1234_5678).
module tb_seg_disp_ctrl;

    localparam int unsigned BLANK_CYC = 8;
    localparam int unsigned MIN_GAP   = 16;
    localparam logic [31:0] INIT_VAL  = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_data = 32'd0;
    logic [3:0]  cpu_be = 4'd0;
    logic        cpu_gnt;
    logic        dbg_req = 1'b0;
    logic [31:0] dbg_data = 32'd0;
    logic [3:0]  dbg_be = 4'd0;
    logic        dbg_gnt;
    logic        busy;
    logic [7:0]  z1, r1, z2, r2;
    logic        upd_done;

    int n_checks = 0;
    int n_fail   = 0;

    seg_disp_ctrl #(
        .BLANK_CYC(BLANK_CYC),
        .MIN_GAP  (MIN_GAP),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cpu_req (cpu_req),
        .cpu_data(cpu_data),
        .cpu_be  (cpu_be),
        .cpu_gnt (cpu_gnt),
        .dbg_req (dbg_req),
        .dbg_data(dbg_data),
        .dbg_be  (dbg_be),
        .dbg_gnt (dbg_gnt),
        .busy    (busy),
        .z1      (z1),
        .r1      (r1),
        .z2      (z2),
        .r2      (r2),
        .upd_done(upd_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Returns the number of falling edges until a grant is seen (first edge after E0 is 1).
    task automatic wait_gnt(input string tag, output logic got_cpu, output logic got_dbg,
                            output int k);
        k = 0;
        got_cpu = 1'b0;
        got_dbg = 1'b0;
        while (k < 100 && !got_cpu && !got_dbg) begin
            @(negedge clk);
            k++;
            got_cpu = cpu_gnt;
            got_dbg = dbg_gnt;
        end
        if (!got_cpu && !got_dbg) check_eq({tag, "_gnt_timeout"}, 32'd0, 32'd1);
    endtask

    // Called at the gnt cycle (cycle 1); ends at cycle BLANK_CYC+1.
    task automatic check_phase(input string tag, input logic [31:0] exp_bytes);
        int bad = 0;
        check_eq({tag, "_busy_c1"}, {31'd0, busy}, 32'd1);
        for (int i = 2; i <= int'(BLANK_CYC); i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || upd_done !== 1'b0 || cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0)
                bad++;
        end
        check_eq({tag, "_blank_bad"}, bad, 32'd0);
        @(negedge clk);
        check_eq({tag, "_busy_c9"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_upd_done"}, {31'd0, upd_done}, 32'd1);
        check_eq({tag, "_bytes"}, {z1, r1, z2, r2}, exp_bytes);
    endtask

    logic gc, gd;
    int   k;
    int   bad;
    logic [31:0] exp_seq_dbg;

    initial begin
        // Reset
        #12;
        check_eq("rst_bytes_in_reset", {z1, r1, z2, r2}, INIT_VAL);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_bytes", {z1, r1, z2, r2}, 32'h1234_5678);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_gnt", {30'd0, cpu_gnt, dbg_gnt}, 32'd0);
        check_eq("rst_upd_done", {31'd0, upd_done}, 32'd0);

        // Single CPU write
        cpu_data = 32'hAABB_CCDD;
        cpu_be   = 4'hF;
        cpu_req  = 1'b1;
        wait_gnt("wr1", gc, gd, k);
        cpu_req = 1'b0;
        check_eq("wr1_gnt_cycle", k, 32'd1);
        check_eq("wr1_who", {30'd0, gc, gd}, 32'd2);
        check_phase("wr1", 32'hAABB_CCDD);
        @(negedge clk);
        check_eq("wr1_upd_done_clr", {31'd0, upd_done}, 32'd0);

        // Byte mask
        cpu_data = 32'h1122_3344;
        cpu_be   = 4'b0101;
        cpu_req  = 1'b1;
        wait_gnt("mask", gc, gd, k);
        cpu_req = 1'b0;
        check_phase("mask", 32'hAA22_CC44);

        // be=0 runs the full sequence with no byte change
        cpu_data = 32'hFFFF_FFFF;
        cpu_be   = 4'b0000;
        cpu_req  = 1'b1;
        wait_gnt("be0", gc, gd, k);
        cpu_req = 1'b0;
        check_eq("be0_who", {30'd0, gc, gd}, 32'd2);
        check_phase("be0", 32'hAA22_CC44);

        // Gap enforcement with cpu_req held high
        cpu_data = 32'h0102_0304;
        cpu_be   = 4'hF;
        cpu_req  = 1'b1;
        wait_gnt("gap1", gc, gd, k);
        check_phase("gap1", 32'h0102_0304);
        cpu_data = 32'h0506_0708;
        wait_gnt("gap2", gc, gd, k);
        cpu_req = 1'b0;
        check_eq("gap_second_gnt_cycle", BLANK_CYC + 1 + k, BLANK_CYC + 2 + MIN_GAP + 1);
        check_phase("gap2", 32'h0506_0708);

        // Reset in cycle 4 of BLANK
        cpu_data = 32'hDEAD_BEEF;
        cpu_req  = 1'b1;
        wait_gnt("mid", gc, gd, k);
        cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_bytes", {z1, r1, z2, r2}, INIT_VAL);
        check_eq("mid_gnt_upd", {29'd0, cpu_gnt, dbg_gnt, upd_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (upd_done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check_eq("mid_no_upd_after", bad, 32'd0);
        check_eq("mid_bytes_after", {z1, r1, z2, r2}, INIT_VAL);

        // Simultaneous requests from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cpu_data = 32'hC0C1_C2C3;
        cpu_be   = 4'hF;
        dbg_data = 32'hD0D1_D2D3;
        dbg_be   = 4'hF;
        cpu_req  = 1'b1;
        dbg_req  = 1'b1;
`ifdef SEG_DISP_RR_ARB_EN
        exp_seq_dbg = 32'b0;
        for (int g = 0; g < 4; g++) begin
            wait_gnt("rr", gc, gd, k);
            check_eq("rr_who", {30'd0, gc, gd}, (g % 2 == 0) ? 32'd2 : 32'd1);
            check_phase("rr", (g % 2 == 0) ? 32'hC0C1_C2C3 : 32'hD0D1_D2D3);
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
`else
        exp_seq_dbg = 32'b1;
        wait_gnt("fp1", gc, gd, k);
        dbg_req = 1'b0;
        check_eq("fp1_who", {30'd0, gc, gd}, 32'd1);
        check_eq("fp1_gnt_cycle", k, exp_seq_dbg);
        check_phase("fp1", 32'hD0D1_D2D3);
        wait_gnt("fp2", gc, gd, k);
        cpu_req = 1'b0;
        check_eq("fp2_who", {30'd0, gc, gd}, 32'd2);
        check_eq("fp2_gnt_cycle", BLANK_CYC + 1 + k, BLANK_CYC + 2 + MIN_GAP + 1);
        check_phase("fp2", 32'hC0C1_C2C3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_disp_ctrl.md
# seg_disp_ctrl

Update controller and two-requester arbiter for the 8-digit seven-segment display driver. It owns the four display bytes (z1, r1, z2, r2) and the driver's `busy` input. It accepts byte-masked 32-bit writes from the CPU MMIO path and from the debug/switch path. Each accepted write is sequenced as a blanking phase (scan held at digit 0), then an atomic commit, then a rate-limiting gap.

## Interface
Parameters:
- `BLANK_CYC`, default 8: cycles `busy` is held high per update; legal range 1..255.
- `MIN_GAP`, default 16: IDLE cycles after a commit before requests are sampled again; legal range 0..255.
- `INIT_VAL`, default 32'h0000_0000: reset contents of {z1,r1,z2,r2}.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: CPU write request; held until `cpu_gnt` is seen.
- `cpu_data` in 32: CPU write data; byte mapping [31:24]→z1, [23:16]→r1, [15:8]→z2, [7:0]→r2.
- `cpu_be` in 4: CPU byte enables; be[3]→z1 … be[0]→r2.
- `cpu_gnt` out 1: one-cycle accept pulse for the CPU.
- `dbg_req`, `dbg_data`, `dbg_be`, `dbg_gnt`: same as the CPU set, for the debug requester.
- `busy` out 1: to the display driver; high blanks and restarts the scan.
- `z1`, `r1`, `z2`, `r2` out 8 each: display bytes.
- `upd_done` out 1: one-cycle pulse in the cycle the new bytes first appear.

## Operation
- FSM states:
  - IDLE: sample requests when `gap_cnt`==0; otherwise decrement `gap_cnt` and ignore requests.
  - BLANK: `busy`=1 while `blk_cnt` counts down.
  - COMMIT: one cycle; `upd_done`=1.
- IDLE→BLANK, on a clock edge where `gap_cnt`==0 and any request is high:
  - the winner's data and be are latched into the pending registers;
  - the winner's gnt is set to 1 and `busy` to 1;
  - `blk_cnt` is loaded with BLANK_CYC-1.
- BLANK:
  - gnt returns to 0 after one cycle.
  - When `blk_cnt`==0: go to COMMIT. On the same edge, `busy` drops to 0, `upd_done` is set, and each byte whose be bit is 1 takes its pending value. Bytes with be=0 hold.
  - Otherwise decrement `blk_cnt`.
- COMMIT→IDLE unconditionally. `upd_done` clears and `gap_cnt` is loaded with MIN_GAP.
- Requests are not sampled in BLANK or COMMIT. A requester that keeps `req` high during its gnt cycle does not create a second request. Requester data/be must be stable while `req` is high and before gnt.
- be=4'b0000 runs the full sequence: gnt, blanking and `upd_done` all occur, and the bytes are unchanged.
- Arbitration (default, fixed priority): `dbg_req` wins over `cpu_req`. The losing request stays pending, unacknowledged, until a later sample.
- Reset values: `busy`=0, both gnts 0, `upd_done`=0, bytes = INIT_VAL, state=IDLE, `gap_cnt`=0, `blk_cnt`=0, RR pointer = "dbg last".

## Timing
- Let E0 be the edge that accepts a request. Cycle numbers below count cycles after E0.
  - Cycle 1: gnt=1.
  - Cycles 1..BLANK_CYC: `busy`=1.
  - Cycle BLANK_CYC+1: new bytes visible and `upd_done`=1.
- Update latency from the accept edge to visible bytes is BLANK_CYC+1 cycles.
- Earliest next accept edge is at the end of cycle BLANK_CYC+2+MIN_GAP.
  - With MIN_GAP=0, this is the end of the first IDLE cycle.
- Because `busy` is held ≥1 cycle, the driver restarts at digit 0 on every update.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Asserting rst_n low mid-BLANK or mid-COMMIT:
  - all outputs immediately take their reset values;
  - the pending write is discarded, with no `upd_done`, even though gnt was already issued.

## Configuration
- Macro `SEG_DISP_RR_ARB_EN`.
  - Defined: round-robin arbitration. On a simultaneous request, the requester not granted last wins. The pointer updates on every grant, and its reset value makes the CPU win the first tie. A single request always wins.
  - Undefined: fixed priority, debug over CPU. The pointer logic is absent.

## Test plan
- Reset: rst_n low then high with INIT_VAL=32'h1234_5678 → z1=8'h12, r1=8'h34, z2=8'h56, r2=8'h78; `busy`=0; no gnt.
- Single CPU write (BLANK_CYC=8): `cpu_data`=32'hAABB_CCDD, be=4'hF → `cpu_gnt` in cycle 1; `busy` high in cycles 1–8; bytes AA/BB/CC/DD with `upd_done` in cycle 9.
- Byte mask: from AA/BB/CC/DD, write 32'h1122_3344 with be=4'b0101 → z1=AA, r1=22, z2=CC, r2=44.
- Simultaneous requests: `cpu_req` and `dbg_req` both high with distinct data.
  - Fixed priority: dbg granted first; CPU granted at the first legal sample after the MIN_GAP gap.
  - With `SEG_DISP_RR_ARB_EN`: CPU first, then dbg; with both still requesting, grants alternate cpu, dbg, cpu, dbg.
- Gap enforcement (MIN_GAP=16): `cpu_req` held high continuously → the second `cpu_gnt` arrives exactly BLANK_CYC+2+MIN_GAP+1 = 27 cycles after the first.
- Reset mid-operation: rst_n low at cycle 4 of BLANK → `busy`=0 immediately; bytes = INIT_VAL; no `upd_done` after release.
